// File: rtl/imm_extend_pipe.sv
// Decode-stage immediate generator with a 2-entry skid output.
// Extends at the input and stores only the extended payload.
module imm_extend_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic             s;
    logic [XLEN-1:0]  immNext;
    logic             illNext;
    logic             accept;
    logic             skidValid;
    logic [XLEN-1:0]  skidImm;
    logic [TAG_W-1:0] skidTag;
    logic             skidIll;
    logic             unusedInstr;

    assign s           = in_instr[31];
    assign unusedInstr = ^in_instr[6:0];
    assign illNext     = (in_imm_src[2:1] == 2'b11);
    assign in_ready    = ~skidValid;
    assign accept      = in_valid & ~skidValid;

    // U keeps b31 as its own top bit so XLEN=32 needs no zero-width fill
    always_comb begin
        immNext = '0;
        unique case (1'b1)
            (in_imm_src == 3'b000):
                immNext = {{(XLEN-12){s}}, in_instr[31:20]};
            (in_imm_src == 3'b001):
                immNext = {{(XLEN-12){s}}, in_instr[31:25],
                           in_instr[11:7]};
            (in_imm_src == 3'b010):
                immNext = {{(XLEN-12){s}}, in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            (in_imm_src == 3'b011):
                immNext = {{(XLEN-20){s}}, in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            (in_imm_src == 3'b100):
                immNext = {{(XLEN-31){s}}, in_instr[30:12], 12'b0};
            (in_imm_src == 3'b101):
                immNext = {{(XLEN-5){1'b0}}, in_instr[19:15]};
            default:
                immNext = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_imm     <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
            skidValid   <= 1'b0;
            skidImm     <= '0;
            skidTag     <= '0;
            skidIll     <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            skidValid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            if (skidValid) begin
                out_valid   <= 1'b1;
                out_imm     <= skidImm;
                out_tag     <= skidTag;
                out_illegal <= skidIll;
                skidValid   <= 1'b0;
            end else begin
                out_valid <= accept;
                if (accept) begin
                    out_imm     <= immNext;
                    out_tag     <= in_tag;
                    out_illegal <= illNext;
                end
            end
        end else if (accept) begin
            skidValid <= 1'b1;
            skidImm   <= immNext;
            skidTag   <= in_tag;
            skidIll   <= illNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (accept && illNext && !flush
                     && illegal_cnt != '1) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: a 32-bit/CNT_W=4 build
// and a 64-bit build share one stimulus stream.
module tb_imm_extend_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_imm_src;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        rdyA, vldA, illA;
    logic [31:0] immA, tagA;
    logic [3:0]  cntA;
    logic        rdyB, vldB, illB;
    logic [63:0] immB;
    logic [31:0] tagB;
    logic [15:0] cntB;

    int nChk;
    int nBad;

    imm_extend_pipe #(.XLEN(32), .TAG_W(32), .CNT_W(4)) dutA (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdyA),
        .in_instr(in_instr), .in_imm_src(in_imm_src),
        .in_tag(in_tag), .out_valid(vldA),
        .out_ready(out_ready), .out_imm(immA),
        .out_tag(tagA), .out_illegal(illA),
        .illegal_cnt(cntA)
    );

    imm_extend_pipe #(.XLEN(64), .TAG_W(32), .CNT_W(16)) dutB (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdyB),
        .in_instr(in_instr), .in_imm_src(in_imm_src),
        .in_tag(in_tag), .out_valid(vldB),
        .out_ready(out_ready), .out_imm(immB),
        .out_tag(tagB), .out_illegal(illB),
        .illegal_cnt(cntB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nChk++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  src;
        logic [31:0] instr;
        logic [31:0] e32;
        logic [63:0] e64;
    } vec_t;

    vec_t vecs[7];
    int   k, nextExp;
    logic acc, fire;
    logic [31:0] ft;

    initial begin
        nChk = 0;
        nBad = 0;
        vecs[0] = '{3'b000, 32'hFFF00093, 32'hFFFFFFFF,
                    64'hFFFFFFFFFFFFFFFF};
        vecs[1] = '{3'b001, 32'hFE20AE23, 32'hFFFFFFFC,
                    64'hFFFFFFFFFFFFFFFC};
        vecs[2] = '{3'b010, 32'hFE000EE3, 32'hFFFFFFFC,
                    64'hFFFFFFFFFFFFFFFC};
        vecs[3] = '{3'b011, 32'hFFDFF06F, 32'hFFFFFFFC,
                    64'hFFFFFFFFFFFFFFFC};
        vecs[4] = '{3'b101, 32'h000F8000, 32'h0000001F,
                    64'h000000000000001F};
        vecs[5] = '{3'b100, 32'h800000B7, 32'h80000000,
                    64'hFFFFFFFF80000000};
        vecs[6] = '{3'b101, 32'h800F8000, 32'h0000001F,
                    64'h000000000000001F};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_instr = '0; in_imm_src = '0; in_tag = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_vld", vldA, 0);
        chk("rst_rdy", rdyA, 1);
        chk("rst_imm", immA, 0);
        chk("rst_tag", tagA, 0);
        chk("rst_ill", illA, 0);
        chk("rst_cnt", cntA, 0);
        rst_n = 1'b1;
        step();

        // one immediate type per cycle, 1-cycle latency
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_imm_src = vecs[i].src;
            in_instr = vecs[i].instr;
            in_tag = 32'(100 + i);
            step();
            chk($sformatf("t%0d_vld", i), vldA, 1);
            chk($sformatf("t%0d_imm32", i), immA, vecs[i].e32);
            chk($sformatf("t%0d_imm64", i), immB, vecs[i].e64);
            chk($sformatf("t%0d_tag", i), tagA, 32'(100 + i));
            chk($sformatf("t%0d_ill", i), illA, 0);
        end
        in_valid = 1'b0;
        step();
        chk("drain_vld", vldA, 0);

        // backpressure: capacity 2, then FIFO release
        k = 1;
        nextExp = 1;
        in_imm_src = 3'b000;
        in_instr = 32'h00100093;
        for (int c = 0; c < 14; c++) begin
            out_ready = (c >= 4);
            in_valid = (k <= 4);
            in_tag = k;
            if (c == 3) begin
                chk("bp_rdy_low", rdyA, 0);
                chk("bp_head", tagA, 1);
            end
            if (c == 4) chk("bp_acc", k, 3);
            acc = in_valid && rdyA;
            fire = vldA && out_ready;
            ft = tagA;
            step();
            if (acc) k++;
            if (fire) begin
                chk("bp_order", ft, nextExp);
                if (c - 3 != nextExp)
                    chk("bp_gap", c, nextExp + 3);
                nextExp++;
            end
        end
        chk("bp_count", nextExp, 5);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();

        // illegal select and counter saturation
        in_valid = 1'b1;
        in_imm_src = 3'b111;
        in_instr = 32'hFFFFFFFF;
        in_tag = 32'h55;
        step();
        chk("ill_imm", immA, 0);
        chk("ill_flag", illA, 1);
        chk("ill_cnt1", cntA, 1);
        chk("ill_tag", tagA, 32'h55);
        for (int i = 0; i < 18; i++) step();
        chk("ill_sat", cntA, 4'hF);
        chk("ill_cnt64", cntB, 19);
        in_valid = 1'b0;
        step();

        // flush with both entries full
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_imm_src = 3'b000;
        step();
        step();
        chk("fl_full", rdyA, 0);
        in_imm_src = 3'b111;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_vld", vldA, 0);
        chk("fl_rdy", rdyA, 1);
        chk("fl_cnt", cntB, 19);
        // flush drops an accepted illegal without counting it
        in_valid = 1'b1;
        in_imm_src = 3'b110;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_drop_vld", vldA, 0);
        chk("fl_drop_cnt", cntB, 19);
        out_ready = 1'b1;

        // async reset between edges
        in_valid = 1'b1;
        in_imm_src = 3'b000;
        in_instr = 32'hFFF00093;
        in_tag = 32'hAB;
        step();
        chk("ar_pre", vldA, 1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_vld", vldA, 0);
        chk("ar_imm", immA, 0);
        chk("ar_tag", tagA, 0);
        chk("ar_ill", illA, 0);
        chk("ar_cnt", cntB, 0);
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_imm_src = 3'b101;
        in_instr = 32'h000F8000;
        in_tag = 32'h77;
        step();
        chk("ar_res_vld", vldA, 1);
        chk("ar_res_imm", immA, 32'h1F);
        chk("ar_res_tag", tagA, 32'h77);
        in_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", nChk, nBad);
        $finish;
    end

endmodule
